// File: rtl/pc_watch_unit.sv
// pc_watch_unit -- program-counter watchpoint unit.
//
// Each channel compares the core program address against a configured
// watch address. A channel reports one hit when the match condition
// first appears (rising edge of the registered match), so a PC that
// stays on the watch address produces one hit, not one per cycle.
// Depending on its mode, a hit bumps a saturating counter, requests a
// core halt, or counts up to a threshold and then requests a halt.
//
// Modes: 0 off, 1 count, 2 halt on every hit, 3 count then halt at threshold.
//
// Ports (pc_watch_unit):
//   clock       single clock, rising edge
//   reset       synchronous active-high reset
//   pc_addr     core program address
//   pc_valid    pc_addr is meaningful this cycle
//   cfg_we      write configuration of channel cfg_ch
//   cfg_ch      channel selected by cfg_we / clr_ch (values >= NUM_CH ignored)
//   cfg_addr    watch address
//   cfg_mode    channel mode
//   cfg_thresh  mode-3 threshold (0 = never halt)
//   clr_ch      clear the selected channel's counter
//   resume      release an active halt
//   ch_hit      one-cycle hit pulse per channel
//   ch_count    packed hit counters, channel 0 in the LSBs
//   halt_req    sticky halt request, high for the whole HALTED state
//   halt_ch     channel that caused the current halt

// Per-channel comparator, edge detector and saturating counter.
module pc_watch_ch #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic              pc_valid,
    input  logic              sel_we,
    input  logic              sel_clr,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [1:0]        cfg_mode,
    input  logic [CNT_W-1:0]  cfg_thresh,
    output logic              hit,
    output logic [CNT_W-1:0]  count,
    output logic              halt_ev
);
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        mode_q;
    logic [CNT_W-1:0]  thresh_q;
    logic              match_q;
    logic              match;
    logic              rise;
    logic [CNT_W-1:0]  inc;

    assign match = pc_valid && (pc_addr == addr_q) && (mode_q != 2'd0);
    // A write or clear aimed at this channel wins over a simultaneous hit.
    assign rise  = match && !match_q && !sel_we && !sel_clr;
    assign inc   = (count == {CNT_W{1'b1}}) ? count : count + CNT_W'(1);

    // halt_ev is combinational so the top can register halt_req on the
    // same edge that registers the hit pulse.
    assign halt_ev = rise && ((mode_q == 2'd2) ||
                     ((mode_q == 2'd3) && (thresh_q != '0) && (inc == thresh_q)));

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q   <= '0;
            mode_q   <= 2'd0;
            thresh_q <= '0;
            match_q  <= 1'b0;
            hit      <= 1'b0;
            count    <= '0;
        end else if (sel_we) begin
            addr_q   <= cfg_addr;
            mode_q   <= cfg_mode;
            thresh_q <= cfg_thresh;
            match_q  <= 1'b0;
            hit      <= 1'b0;
            count    <= '0;
        end else begin
            match_q <= match;
            hit     <= rise;
            if (sel_clr)
                count <= '0;
            else if (rise && mode_q[0])   // modes 1 and 3 count
                count <= inc;
        end
    end
endmodule

module pc_watch_unit #(
    parameter int ADDR_W = 32,
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDR_W-1:0]       pc_addr,
    input  logic                    pc_valid,
    input  logic                    cfg_we,
    input  logic [CH_W-1:0]         cfg_ch,
    input  logic [ADDR_W-1:0]       cfg_addr,
    input  logic [1:0]              cfg_mode,
    input  logic [CNT_W-1:0]        cfg_thresh,
    input  logic                    clr_ch,
    input  logic                    resume,
    output logic [NUM_CH-1:0]       ch_hit,
    output logic [NUM_CH*CNT_W-1:0] ch_count,
    output logic                    halt_req,
    output logic [CH_W-1:0]         halt_ch
);
    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    logic [NUM_CH-1:0][CNT_W-1:0] cnt;
    logic [NUM_CH-1:0]            halt_ev;
    logic                         ch_ok;
    logic [CH_W-1:0]              halt_sel;
    logic [0:0]                   state;

    // Out-of-range channel numbers select nothing.
    assign ch_ok = {1'b0, cfg_ch} < (CH_W+1)'(NUM_CH);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pc_watch_ch #(
            .ADDR_W (ADDR_W),
            .CNT_W  (CNT_W)
        ) u_ch (
            .clock      (clock),
            .reset      (reset),
            .pc_addr    (pc_addr),
            .pc_valid   (pc_valid),
            .sel_we     (cfg_we && ch_ok && (cfg_ch == CH_W'(i))),
            .sel_clr    (clr_ch && ch_ok && (cfg_ch == CH_W'(i))),
            .cfg_addr   (cfg_addr),
            .cfg_mode   (cfg_mode),
            .cfg_thresh (cfg_thresh),
            .hit        (ch_hit[i]),
            .count      (cnt[i]),
            .halt_ev    (halt_ev[i])
        );
    end

    assign ch_count = cnt;

    // Lowest-index channel wins; scanning downward lets the last write win.
    always_comb begin
        halt_sel = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (halt_ev[i]) halt_sel = CH_W'(i);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_RUN;
            halt_ch <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (|halt_ev) begin
                        state   <= ST_HALTED;
                        halt_ch <= halt_sel;
                    end
                end
                default: begin
                    // A fresh halt event beats resume and retargets halt_ch;
                    // without resume, further events leave halt_ch alone.
                    if ((|halt_ev) && resume)
                        halt_ch <= halt_sel;
                    else if (resume)
                        state <= ST_RUN;
                end
            endcase
        end
    end

    assign halt_req = (state == ST_HALTED);
endmodule

// File: tb/tb_pc_watch_unit.sv
module tb_pc_watch_unit;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pc_addr;
    logic        pc_valid;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [31:0] cfg_addr;
    logic [1:0]  cfg_mode;
    logic [15:0] cfg_thresh;
    logic        clr_ch;
    logic        resume;
    logic [3:0]  ch_hit;
    logic [63:0] ch_count;
    logic        halt_req;
    logic [1:0]  halt_ch;

    logic [3:0]  s_hit;
    logic [15:0] s_count;
    logic        s_halt_req;
    logic [1:0]  s_halt_ch;

    int passed = 0;
    int total  = 0;
    int pulses0;

    always #5 clock = ~clock;

    pc_watch_unit dut (
        .clock(clock), .reset(reset), .pc_addr(pc_addr), .pc_valid(pc_valid),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr), .cfg_mode(cfg_mode),
        .cfg_thresh(cfg_thresh), .clr_ch(clr_ch), .resume(resume),
        .ch_hit(ch_hit), .ch_count(ch_count), .halt_req(halt_req), .halt_ch(halt_ch)
    );

    // Narrow-counter copy sharing the same stimulus, used for saturation.
    pc_watch_unit #(.CNT_W(4)) dut_s (
        .clock(clock), .reset(reset), .pc_addr(pc_addr), .pc_valid(pc_valid),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr), .cfg_mode(cfg_mode),
        .cfg_thresh(cfg_thresh[3:0]), .clr_ch(clr_ch), .resume(resume),
        .ch_hit(s_hit), .ch_count(s_count), .halt_req(s_halt_req), .halt_ch(s_halt_ch)
    );

    task automatic tick();
        @(posedge clock);
        #1;
        pulses0 += int'(ch_hit[0]);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [31:0] a,
                       input logic [1:0] m, input logic [15:0] th);
        cfg_we = 1'b1; cfg_ch = ch; cfg_addr = a; cfg_mode = m; cfg_thresh = th;
        pc_valid = 1'b0;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pc(input logic [31:0] a);
        pc_addr = a; pc_valid = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b1; pc_addr = '0; pc_valid = 1'b0; cfg_we = 1'b0; cfg_ch = '0;
        cfg_addr = '0; cfg_mode = '0; cfg_thresh = '0; clr_ch = 1'b0; resume = 1'b0;
        pulses0 = 0;
        tick(); tick();
        chk("rst_hit", {60'd0, ch_hit}, 64'd0);
        chk("rst_count", ch_count, 64'd0);
        chk("rst_halt", {63'd0, halt_req}, 64'd0);
        chk("rst_halt_ch", {62'd0, halt_ch}, 64'd0);
        reset = 1'b0;

        // Mode 0 channels at address 0 never hit.
        pc(32'h0);
        chk("mode0_nohit", {60'd0, ch_hit}, 64'd0);

        // pc_valid low while on the watch address.
        cfg(2'd0, 32'h1D04, 2'd1, 16'd0);
        pc_addr = 32'h1D04; pc_valid = 1'b0; tick();
        chk("novalid_hit", {60'd0, ch_hit}, 64'd0);
        chk("novalid_cnt", {48'd0, ch_count[15:0]}, 64'd0);

        // Held address gives one hit; leave and return gives a second.
        pulses0 = 0;
        pc(32'h1D04);
        chk("hold_first_hit", {60'd0, ch_hit}, 64'h1);
        chk("hold_first_cnt", {48'd0, ch_count[15:0]}, 64'd1);
        for (int k = 0; k < 4; k++) pc(32'h1D04);
        chk("hold_cnt", {48'd0, ch_count[15:0]}, 64'd1);
        pc(32'h1D08);
        pc(32'h1D04);
        pc(32'h1D08);
        chk("back_cnt", {48'd0, ch_count[15:0]}, 64'd2);
        chk("pulses", 64'(pulses0), 64'd2);

        // Mode 3 threshold 3: halt with the third hit.
        cfg(2'd1, 32'h2000, 2'd3, 16'd3);
        pc(32'h2000); pc(32'h3000);
        pc(32'h2000); pc(32'h3000);
        chk("m3_nohalt", {63'd0, halt_req}, 64'd0);
        pc(32'h2000);
        chk("m3_hit", {60'd0, ch_hit}, 64'h2);
        chk("m3_halt", {63'd0, halt_req}, 64'd1);
        chk("m3_halt_ch", {62'd0, halt_ch}, 64'd1);
        chk("m3_cnt", {48'd0, ch_count[31:16]}, 64'd3);
        resume = 1'b1; pc(32'h3000); resume = 1'b0;
        chk("m3_resume", {63'd0, halt_req}, 64'd0);

        // Two halting channels on one address: lowest index wins.
        cfg(2'd0, 32'h4000, 2'd2, 16'd0);
        cfg(2'd2, 32'h4000, 2'd2, 16'd0);
        pc(32'h4000);
        chk("dual_hit", {60'd0, ch_hit}, 64'h5);
        chk("dual_halt", {63'd0, halt_req}, 64'd1);
        chk("dual_halt_ch", {62'd0, halt_ch}, 64'd0);
        pc(32'h3000);
        cfg(2'd2, 32'h5000, 2'd2, 16'd0);
        chk("dual_still_halt", {63'd0, halt_req}, 64'd1);
        resume = 1'b1; pc(32'h5000);
        chk("prio_halt", {63'd0, halt_req}, 64'd1);
        chk("prio_halt_ch", {62'd0, halt_ch}, 64'd2);
        pc(32'h3000); resume = 1'b0;
        chk("prio_release", {63'd0, halt_req}, 64'd0);

        // Write to ch0 during a ch0 match suppresses the hit.
        pc_addr = 32'h4000; pc_valid = 1'b1;
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_addr = 32'h4000; cfg_mode = 2'd1; cfg_thresh = 16'd0;
        tick(); cfg_we = 1'b0;
        chk("we_nohit", {60'd0, ch_hit}, 64'd0);
        chk("we_cnt", {48'd0, ch_count[15:0]}, 64'd0);
        chk("we_nohalt", {63'd0, halt_req}, 64'd0);
        pc(32'h3000);
        pc(32'h4000); pc(32'h3000);
        chk("clr_pre_cnt", {48'd0, ch_count[15:0]}, 64'd1);
        clr_ch = 1'b1; cfg_ch = 2'd0; pc(32'h4000); clr_ch = 1'b0;
        chk("clr_nohit", {60'd0, ch_hit}, 64'd0);
        chk("clr_cnt", {48'd0, ch_count[15:0]}, 64'd0);

        // Reset while HALTED clears everything on the next edge.
        pc(32'h5000);
        chk("pre_rst_halt", {63'd0, halt_req}, 64'd1);
        reset = 1'b1; pc_valid = 1'b0; tick(); reset = 1'b0;
        chk("mid_rst_halt", {63'd0, halt_req}, 64'd0);
        chk("mid_rst_halt_ch", {62'd0, halt_ch}, 64'd0);
        chk("mid_rst_hit", {60'd0, ch_hit}, 64'd0);
        chk("mid_rst_count", ch_count, 64'd0);

        // 20 hits: 16-bit counter reaches 20, 4-bit counter sticks at 15.
        cfg(2'd0, 32'h7000, 2'd1, 16'd0);
        for (int k = 0; k < 20; k++) begin
            pc(32'h7000); pc(32'h7004);
        end
        chk("sat_wide", {48'd0, ch_count[15:0]}, 64'd20);
        chk("sat_narrow", {60'd0, s_count[3:0]}, 64'd15);

        // Mode 3 with threshold 0 counts but never halts.
        cfg(2'd3, 32'h8000, 2'd3, 16'd0);
        pc(32'h8000);
        chk("th0_hit", {60'd0, ch_hit}, 64'h8);
        chk("th0_cnt", {48'd0, ch_count[63:48]}, 64'd1);
        chk("th0_nohalt", {63'd0, halt_req}, 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pc_watch_unit.md
PC_WATCH_UNIT -- requirements
Module: pc_watch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of the program address being watched.
REQ-002 SHALL have parameter NUM_CH, default 4, number of watch channels (1..16).
REQ-003 SHALL have parameter CNT_W, default 16, width of each channel hit counter.
REQ-004 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port pc_addr  input  ADDR_W  core program address (byte address).
REQ-007 SHALL have port pc_valid  input  1  pc_addr is meaningful this cycle (core step strobe).
REQ-008 SHALL have port cfg_we  input  1  write one channel's configuration.
REQ-009 SHALL have port cfg_ch  input  clog2(NUM_CH) (min 1)  channel selected by cfg_we/clr_ch.
REQ-010 SHALL have port cfg_addr  input  ADDR_W  watch address for the channel.
REQ-011 SHALL have port cfg_mode  input  2  mode: 0 off, 1 count, 2 halt on every hit, 3 count then halt at threshold.
REQ-012 SHALL have port cfg_thresh  input  CNT_W  threshold for mode 3.
REQ-013 SHALL have port clr_ch  input  1  clear the selected channel's counter.
REQ-014 SHALL have port resume  input  1  release an active halt.
REQ-015 SHALL have port ch_hit  output  NUM_CH  one-cycle hit pulse per channel.
REQ-016 SHALL have port ch_count  output  NUM_CH*CNT_W  packed counters, channel 0 in LSBs.
REQ-017 SHALL have port halt_req  output  1  sticky halt request to the core clock gate.
REQ-018 SHALL have port halt_ch  output  clog2(NUM_CH) (min 1)  channel that caused the current halt.

Function
REQ-019 SHALL compute, per channel, match = pc_valid & (pc_addr == cfg_addr) & (mode != 0).
REQ-020 SHALL register match per channel and declare a hit only on its rising edge; a PC held on the watch address for N cycles SHALL give exactly one hit.
REQ-021 SHALL assert ch_hit[i] for exactly one cycle, the cycle after the match-rising sample (latency 1).
REQ-022 SHALL increment counter i on each hit in modes 1 and 3; the counter SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-023 SHALL not change counter i on hits in modes 0 and 2.
REQ-024 SHALL raise halt_req on the cycle ch_hit[i] asserts, in mode 2, or in mode 3 when the incremented count equals cfg_thresh.
REQ-025 SHALL, in mode 3 with cfg_thresh = 0, never halt.
REQ-026 SHALL run a two-state FSM, RUN and HALTED: RUN→HALTED on any halt event; HALTED→RUN on resume with no new halt event that cycle.
REQ-027 SHALL hold halt_req = 1 for the whole HALTED state and latch halt_ch on entry; halt_ch SHALL stay unchanged while HALTED.
REQ-028 SHALL pick the lowest-index channel as halt_ch when several channels raise a halt event in the same cycle.
REQ-029 SHALL give a new halt event priority over resume in the same cycle: stay HALTED and update halt_ch to the new channel.
REQ-030 SHALL keep detecting and counting hits while HALTED, but SHALL not change halt_ch except as REQ-029 states.
REQ-031 SHALL, on cfg_we, load the channel's address, mode and threshold, clear its counter and clear its match history, all in one cycle.
REQ-032 SHALL, when cfg_we or clr_ch targets a channel that also hits in the same cycle, suppress that channel's hit, count and halt event, with the write/clear winning.
REQ-033 SHALL ignore cfg_ch values ≥ NUM_CH.

Reset
REQ-034 SHALL, on reset, drive ch_hit=0, ch_count=0, halt_req=0 and halt_ch=0, set every mode to 0 and address to 0, clear all match history, and enter FSM state RUN.
REQ-035 SHALL make reset take priority over every other input, and SHALL let reset asserted mid-halt release halt_req on the next edge.

Verification
REQ-036 SHALL cover: ch0 mode 1, address 0x1D04, pc_addr held at 0x1D04 for 5 valid cycles, then away, then back → count=2, and exactly 2 ch_hit[0] pulses.
REQ-037 SHALL cover: ch1 mode 3, threshold 3, three separate hits → halt_req rises with the 3rd ch_hit[1] pulse, halt_ch=1 and count=3; resume → halt_req=0 next cycle.
REQ-038 SHALL cover: ch0 and ch2 both mode 2 on the same address, one hit → halt_ch=0; hit ch2 alone while holding resume → stays HALTED with halt_ch=2.
REQ-039 SHALL cover: CNT_W=4 in mode 1 with 20 hits → count saturates at 15.
REQ-040 SHALL cover: cfg_we on ch0 in the same cycle as a ch0 match → no pulse and count=0; reset asserted while HALTED → all outputs 0 next cycle.
REQ-041 SHALL cover: pc_valid=0 while pc_addr equals the watch address → no hit.
